// File: rtl/if_id_buf.sv
// Two-entry elastic buffer between fetch and decode. Head register H drives decode directly.
// Skid register S absorbs one extra pair, so in_ready depends only on registered state.
module if_id_buf #(
  parameter int ISA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ISA_WIDTH-1:0] in_pc,
  input  logic [ISA_WIDTH-1:0] in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ISA_WIDTH-1:0] out_pc,
  output logic [ISA_WIDTH-1:0] out_inst,
  input  logic                 flush,
  output logic [1:0]           count
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               r_state;
  logic [ISA_WIDTH-1:0] r_h_pc;
  logic [ISA_WIDTH-1:0] r_h_inst;
  logic [ISA_WIDTH-1:0] r_s_pc;
  logic [ISA_WIDTH-1:0] r_s_inst;
  logic                 w_push;
  logic                 w_pop;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = (r_state != FULL);
  assign count     = r_state;
  assign out_pc    = r_h_pc;
  assign out_inst  = r_h_inst;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_h_pc   <= '0;
      r_h_inst <= '0;
      r_s_pc   <= '0;
      r_s_inst <= '0;
    end else if (flush) begin
      // Redirect: drop everything, keep stale data so decode sees no glitches.
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_h_pc   <= in_pc;
            r_h_inst <= in_inst;
            r_state  <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_h_pc   <= in_pc;
            r_h_inst <= in_inst;
          end else if (w_push) begin
            r_s_pc   <= in_pc;
            r_s_inst <= in_inst;
            r_state  <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_h_pc   <= r_s_pc;
            r_h_inst <= r_s_inst;
            r_state  <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed vector table for if_id_buf followed by a randomized run against a queue model.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush;
  logic [1:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_buf #(.ISA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .flush    (flush),
    .count    (count)
  );

  // Inputs applied before an edge, expected outputs observed after it.
  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_cnt;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [31:0] pc, logic [31:0] inst,
                              logic ordy, logic fl, logic e_ov, logic e_ir,
                              logic [1:0] e_cnt, logic [31:0] e_pc, logic [31:0] e_inst);
    vec_t v;
    v.rst = r; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] PA = 32'h8000_0000, IA = 32'h0000_0413;
  localparam logic [31:0] PB = 32'h8000_0004, IB = 32'h0010_0073;
  localparam logic [31:0] PC = 32'h8000_0008, IC = 32'h0000_0013;
  localparam logic [31:0] PD = 32'h8000_0020, ID = 32'h0000_00D0;
  localparam logic [31:0] PE = 32'h8000_0030, IE = 32'h0000_00E0;
  localparam logic [31:0] PF = 32'h8000_0040, IF = 32'h0000_00F0;
  localparam logic [31:0] PG = 32'h8000_0050, IG = 32'h0000_0AB0;

  // Random stress model
  logic [63:0] model_q[$];
  logic [31:0] next_pc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;

    //            rst iv pc  inst ordy fl | ov ir cnt pc  inst
    // reset, then idle
    vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 1, 0, 0,  0));
    vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0,  0, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  1, 0,  0, 1, 0, 0,  0));
    // streaming at 1 pair/cycle
    vecs.push_back(mk(0, 1, PA, IA, 1, 0,  1, 1, 1, PA, IA));
    vecs.push_back(mk(0, 1, PB, IB, 1, 0,  1, 1, 1, PB, IB));
    vecs.push_back(mk(0, 1, PC, IC, 1, 0,  1, 1, 1, PC, IC));
    vecs.push_back(mk(0, 0, 0,  0,  1, 0,  0, 1, 0, PC, IC));
    // backpressure fill, push attempt while full is refused, then drain
    vecs.push_back(mk(0, 1, PA, IA, 0, 0,  1, 1, 1, PA, IA));
    vecs.push_back(mk(0, 1, PB, IB, 0, 0,  1, 0, 2, PA, IA));
    vecs.push_back(mk(0, 1, PC, IC, 0, 0,  1, 0, 2, PA, IA));
    vecs.push_back(mk(0, 0, 0,  0,  1, 0,  1, 1, 1, PB, IB));
    vecs.push_back(mk(0, 0, 0,  0,  1, 0,  0, 1, 0, PB, IB));
    // hold A, then push C while popping A
    vecs.push_back(mk(0, 1, PA, IA, 0, 0,  1, 1, 1, PA, IA));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0,  1, 1, 1, PA, IA));
    vecs.push_back(mk(0, 1, PC, IC, 1, 0,  1, 1, 1, PC, IC));
    // fill to FULL, flush with a concurrent push and pop
    vecs.push_back(mk(0, 1, PD, ID, 0, 0,  1, 0, 2, PC, IC));
    vecs.push_back(mk(0, 1, PE, IE, 1, 1,  0, 1, 0, PC, IC));
    vecs.push_back(mk(0, 1, PF, IF, 0, 0,  1, 1, 1, PF, IF));
    // flush from ONE drops the incoming pair
    vecs.push_back(mk(0, 1, PG, IG, 0, 1,  0, 1, 0, PF, IF));
    vecs.push_back(mk(0, 1, PG, IG, 0, 0,  1, 1, 1, PG, IG));
    // reset beats a same-cycle push and pop, and zeroes the head
    vecs.push_back(mk(1, 1, PA, IA, 1, 0,  0, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0,  0, 1, 0, 0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_pc = vecs[i].pc; in_inst = vecs[i].inst;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d count", i),     {30'd0, count},     {30'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d out_pc", i),    out_pc,             vecs[i].e_pc);
      chk($sformatf("v%0d out_inst", i),  out_inst,           vecs[i].e_inst);
    end

    // Random stress: buffer is empty here after the last vector.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    model_q.delete();
    next_pc = 32'h1000_0000;
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl, m_push, m_pop;
      @(negedge clk);
      chk($sformatf("rnd%0d count", c), {30'd0, count}, model_q.size());
      chk($sformatf("rnd%0d in_ready", c), {31'd0, in_ready}, {31'd0, model_q.size() < 2});
      chk($sformatf("rnd%0d out_valid", c), {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      if (model_q.size() != 0) begin
        chk($sformatf("rnd%0d out_pc", c), out_pc, model_q[0][63:32]);
        chk($sformatf("rnd%0d out_inst", c), out_inst, model_q[0][31:0]);
      end
      iv   = ($urandom_range(99) < 60);
      ordy = ($urandom_range(99) < 55);
      fl   = ($urandom_range(99) < 3);
      m_push = iv && (model_q.size() < 2) && !fl;
      m_pop  = ordy && (model_q.size() != 0) && !fl;
      in_valid = iv; out_ready = ordy; flush = fl;
      in_pc = next_pc; in_inst = ~next_pc;
      if (fl) model_q.delete();
      if (m_pop) void'(model_q.pop_front());
      if (m_push) begin
        model_q.push_back({next_pc, ~next_pc});
        next_pc = next_pc + 32'd4;
      end
    end
    @(negedge clk);
    chk("rnd final count", {30'd0, count}, model_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
# if_id_buf

Two-entry elastic buffer between the instruction fetch stage and the instruction decode stage. It accepts {pc, instruction} pairs from fetch over a valid/ready handshake and presents them in order to decode. It decouples decode stalls from fetch with no combinational path from `out_ready` to `in_ready`. A `flush` input discards all buffered instructions on a control-flow redirect.

## Interface
Parameters:
- `ISA_WIDTH`, default 32: width of the pc and instruction fields.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `in_valid`  input  1  fetch presents a valid pair.
- `in_ready`  output  1  buffer can accept a pair this cycle.
- `in_pc`  input  ISA_WIDTH  pc of the incoming instruction.
- `in_inst`  input  ISA_WIDTH  incoming instruction word.
- `out_valid`  output  1  head entry valid for decode.
- `out_ready`  input  1  decode consumes the head this cycle.
- `out_pc`  output  ISA_WIDTH  pc of the head entry.
- `out_inst`  output  ISA_WIDTH  instruction of the head entry.
- `flush`  input  1  discard all entries and any same-cycle input.
- `count`  output  2  occupancy, 0..2.

## Operation
- Storage: head register H = {pc, inst}, skid register S = {pc, inst}, and a state register.
- States: EMPTY (count 0), ONE (H valid), FULL (H and S valid).
- `out_valid` = (state != EMPTY). `out_pc`/`out_inst` are driven directly from H.
- `in_ready` = (state != FULL). It is a function of the state register only.
- push = `in_valid & in_ready & !flush`. pop = `out_valid & out_ready & !flush`.
- Transitions:
  - EMPTY, push: H <= in, go to ONE.
  - EMPTY, no push: stay in EMPTY.
  - ONE, push & !pop: S <= in, go to FULL.
  - ONE, pop & !push: go to EMPTY.
  - ONE, push & pop: H <= in, stay in ONE.
  - ONE, neither: hold.
  - FULL, pop: H <= S, go to ONE. Push cannot occur because `in_ready` = 0.
  - FULL, no pop: hold.
- `flush` = 1: next state is EMPTY regardless of state, `in_valid`, or `out_ready`. The same-cycle input is dropped, and no pop is counted. H and S contents are left unchanged.
- Ordering: entries leave in exact acceptance order. No entry is duplicated or lost except by `flush`.
- `count` = 0/1/2 for EMPTY/ONE/FULL.
- Data registers are written only on the listed transitions. When EMPTY, `out_pc`/`out_inst` hold stale H contents, and decode must qualify them with `out_valid`.

## Timing
- Reset:
  - While `rst` = 1 at an edge: state <= EMPTY, H <= 0, S <= 0; the handshake is ignored.
  - After the first edge with `rst` = 1: `out_valid` = 0, `count` = 0, `out_pc` = 0, `out_inst` = 0, `in_ready` = 1.
- Reset mid-operation: all entries are discarded exactly as with `flush`, plus H and S are zeroed. A reset asserted in the same cycle as a push or pop takes priority.
- Latency: a pair accepted at edge N is visible on `out_*` with `out_valid` = 1 after edge N. Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 pair/cycle sustained when `out_ready` = 1 every cycle (ONE state, simultaneous push and pop).
- Backpressure:
  - With `out_ready` = 0, the buffer absorbs 2 pairs, then `in_ready` drops after the edge that fills S.
  - `in_ready` rises after the edge that pops from FULL.
- Flush priority: `flush` beats push, pop, and hold. `in_ready` is not gated by `flush` in the flush cycle; the dropped input still completes its handshake from fetch's point of view.
- There is no combinational path from `out_ready` or `flush` to `in_ready`, or from `in_valid` to `out_valid`.

## Test plan
- Reset then idle: assert `rst` for 2 cycles and release. Required: `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_pc` = 0, `out_inst` = 0 every cycle until the first push.
- Streaming: `out_ready` = 1, push pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles with insts 0x00000413, 0x00100073, 0x00000013. Required: the same three pairs appear on `out_*` on consecutive cycles, each 1 cycle after acceptance, and `count` stays 1.
- Backpressure fill/drain:
  - With `out_ready` = 0, push A (0x80000000) then B (0x80000004). Required: `count` = 2, `in_ready` = 0, `out_pc` = 0x80000000.
  - Raise `out_ready` for 2 cycles. Required: A then B pop, then EMPTY.
- Simultaneous push/pop in ONE: hold A, then push C while popping A in the same cycle. Required: the next cycle `out_pc` = C's pc and `count` = 1.
- Flush: from FULL, assert `flush` together with `in_valid` = 1 and `out_ready` = 1. Required: the next cycle `count` = 0 and `out_valid` = 0. The dropped input never appears; the next push after flush is the first output.
- Random stress: random `in_valid`/`out_ready`/`flush` over 10k cycles against a queue model. Required: in-order, no loss or duplication outside flush, and `count` matches the model every cycle.
